// File: rtl/tol_result_checker_if.sv
// rtl/tol_result_checker_if.sv - compare beat bundle (valids, golden and device words)
interface tol_result_checker_if #(
  parameter int N_CH  = 4,
  parameter int BIT_L = 32
);
  logic [N_CH-1:0]       in_vld;
  logic [N_CH*BIT_L-1:0] golden;
  logic [N_CH*BIT_L-1:0] sim;

  modport master (output in_vld, golden, sim);
  modport slave  (input  in_vld, golden, sim);
endinterface

// File: rtl/tol_result_checker.sv
// rtl/tol_result_checker.sv - multi-channel tolerance result checker with run framing and error statistics
module tol_result_checker #(
  parameter int N_CH  = 4,
  parameter int BIT_L = 32,
  parameter int CNT_L = 32,
  parameter int SH_L  = $clog2(BIT_L),
  parameter int CH_L  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_L-1:0]       n_expected,
  input  logic                   mode,
  input  logic [BIT_L-1:0]       tol,
  input  logic [SH_L-1:0]        sh,
  tol_result_checker_if.slave    beat,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   overrun,
  output logic [CNT_L-1:0]       n_checked,
  output logic [CNT_L-1:0]       n_err,
  output logic [N_CH-1:0]        err_ch,
  output logic                   first_err_vld,
  output logic [CH_L-1:0]        first_err_ch,
  output logic [CNT_L-1:0]       first_err_idx,
  output logic [BIT_L-1:0]       first_err_golden,
  output logic [BIT_L-1:0]       first_err_sim
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  drain_cnt_q;
  logic [CNT_L-1:0]      n_exp_q, acc_cnt_q;
  logic                  mode_q;
  logic [BIT_L-1:0]      tol_q;
  logic [SH_L-1:0]       sh_q;

  logic [N_CH-1:0]       acc0_q, acc1_q, fail1_q;
  logic [N_CH*BIT_L-1:0] g0_q, s0_q, g1_q, s1_q;

  logic [CNT_L-1:0]      remaining, taken;
  logic [N_CH-1:0]       acc_d, fail_d;
  logic                  drop;

  logic [CNT_L-1:0]      pop_acc, pop_fail, lower;
  logic                  found;
  logic [CH_L-1:0]       fc;
  logic [BIT_L-1:0]      fg, fs;

  function automatic logic [CNT_L-1:0] sat_add(input logic [CNT_L-1:0] a, input logic [CNT_L-1:0] b);
    logic [CNT_L:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_L] ? '1 : sum[CNT_L-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= (state_q == S_DRAIN) && !start ? ~drain_cnt_q : 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_RUN:   if (acc_cnt_q == n_exp_q) state_d = S_DRAIN;
        S_DRAIN: if (drain_cnt_q)          state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    done = (state_q == S_DONE);
    pass = done && (n_err == '0) && !overrun;
  end

  // Quota walk: lowest-index valid channels are accepted first; anything past the quota is dropped.
  always_comb begin
    remaining = n_exp_q - acc_cnt_q;
    taken     = '0;
    acc_d     = '0;
    drop      = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (beat.in_vld[c]) begin
        if (state_q == S_RUN && taken < remaining) begin
          acc_d[c] = 1'b1;
          taken    = taken + CNT_L'(1);
        end else if (state_q != S_IDLE) begin
          drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_exp_q   <= '0;
      acc_cnt_q <= '0;
      mode_q    <= 1'b0;
      tol_q     <= '0;
      sh_q      <= '0;
      overrun   <= 1'b0;
      acc0_q    <= '0;
      g0_q      <= '0;
      s0_q      <= '0;
    end else if (start) begin
      n_exp_q   <= n_expected;
      acc_cnt_q <= '0;
      mode_q    <= mode;
      tol_q     <= tol;
      sh_q      <= sh;
      overrun   <= 1'b0;
      acc0_q    <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_q + taken;
      overrun   <= overrun | drop;
      acc0_q    <= acc_d;
      g0_q      <= beat.golden;
      s0_q      <= beat.sim;
    end
  end

  // Tolerance compare is widened by one bit so sim+tol and golden+tol cannot wrap.
  always_comb begin
    fail_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      logic [BIT_L-1:0] g, s;
      logic             ok;
      g = g0_q[c*BIT_L +: BIT_L];
      s = s0_q[c*BIT_L +: BIT_L];
      if (!mode_q)
        ok = ({1'b0, g} <= {1'b0, s} + {1'b0, tol_q}) && ({1'b0, s} <= {1'b0, g} + {1'b0, tol_q});
      else
        ok = (g >> sh_q) == (s >> sh_q);
      fail_d[c] = acc0_q[c] && !ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc1_q  <= '0;
      fail1_q <= '0;
      g1_q    <= '0;
      s1_q    <= '0;
    end else if (start) begin
      acc1_q  <= '0;
      fail1_q <= '0;
    end else begin
      acc1_q  <= acc0_q;
      fail1_q <= fail_d;
      g1_q    <= g0_q;
      s1_q    <= s0_q;
    end
  end

  always_comb begin
    pop_acc  = '0;
    pop_fail = '0;
    lower    = '0;
    found    = 1'b0;
    fc       = '0;
    fg       = '0;
    fs       = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (fail1_q[c]) begin
        pop_fail = pop_fail + CNT_L'(1);
        if (!found) begin
          found = 1'b1;
          fc    = CH_L'(c);
          lower = pop_acc;
          fg    = g1_q[c*BIT_L +: BIT_L];
          fs    = s1_q[c*BIT_L +: BIT_L];
        end
      end
      if (acc1_q[c]) pop_acc = pop_acc + CNT_L'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_checked        <= '0;
      n_err            <= '0;
      err_ch           <= '0;
      first_err_vld    <= 1'b0;
      first_err_ch     <= '0;
      first_err_idx    <= '0;
      first_err_golden <= '0;
      first_err_sim    <= '0;
    end else if (start) begin
      n_checked        <= '0;
      n_err            <= '0;
      err_ch           <= '0;
      first_err_vld    <= 1'b0;
      first_err_ch     <= '0;
      first_err_idx    <= '0;
      first_err_golden <= '0;
      first_err_sim    <= '0;
    end else if (|acc1_q) begin
      n_checked <= sat_add(n_checked, pop_acc);
      n_err     <= sat_add(n_err, pop_fail);
      err_ch    <= err_ch | fail1_q;
      if (!first_err_vld && found) begin
        first_err_vld    <= 1'b1;
        first_err_ch     <= fc;
        first_err_idx    <= sat_add(n_checked, lower);
        first_err_golden <= fg;
        first_err_sim    <= fs;
      end
    end
  end

endmodule

// File: tb/tb_tol_result_checker.sv
// tb/tb_tol_result_checker.sv - directed self-checking bench for tol_result_checker
module tb_tol_result_checker;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] n_expected;
  logic        mode;
  logic [31:0] tol;
  logic [4:0]  sh;
  logic        busy, done, pass, overrun, first_err_vld;
  logic [31:0] n_checked, n_err, first_err_idx, first_err_golden, first_err_sim;
  logic [3:0]  err_ch;
  logic [1:0]  first_err_ch;

  logic [31:0] g [4];
  logic [31:0] s [4];
  int n_checks = 0;
  int n_errors = 0;

  tol_result_checker_if #(.N_CH(4), .BIT_L(32)) bus ();

  tol_result_checker dut (
    .clk(clk), .rst(rst), .start(start), .n_expected(n_expected), .mode(mode),
    .tol(tol), .sh(sh), .beat(bus.slave), .busy(busy), .done(done), .pass(pass),
    .overrun(overrun), .n_checked(n_checked), .n_err(n_err), .err_ch(err_ch),
    .first_err_vld(first_err_vld), .first_err_ch(first_err_ch),
    .first_err_idx(first_err_idx), .first_err_golden(first_err_golden),
    .first_err_sim(first_err_sim)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bus(input logic [3:0] v);
    bus.in_vld = v;
    for (int c = 0; c < 4; c++) begin
      bus.golden[c*32 +: 32] = g[c];
      bus.sim[c*32 +: 32]    = s[c];
    end
  endtask

  task automatic send(input logic [3:0] v);
    load_bus(v);
    tick();
    bus.in_vld = 4'b0;
  endtask

  task automatic do_start(input logic [31:0] ne, input logic md, input logic [31:0] tl, input logic [4:0] shv);
    n_expected = ne;
    mode       = md;
    tol        = tl;
    sh         = shv;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic set_pm1024();
    g[0] = 32'h0000_1000; g[1] = 32'h2000_0000; g[2] = 32'h0000_5555; g[3] = 32'hFFFF_0000;
    for (int c = 0; c < 4; c++) s[c] = (c % 2 == 0) ? g[c] + 32'd1024 : g[c] - 32'd1024;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n_expected = '0; mode = 1'b0; tol = '0; sh = '0;
    bus.in_vld = '0; bus.golden = '0; bus.sim = '0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_ovr", overrun, 0);
    check("rst_nchk", n_checked, 0);
    check("rst_first", first_err_vld, 0);
    rst = 1'b0;
    tick();

    // beats in IDLE are ignored without overrun
    set_pm1024();
    send(4'hF); tick(); tick();
    check("idle_ovr", overrun, 0);
    check("idle_nchk", n_checked, 0);

    // 1: absolute tolerance, all within +-1024
    do_start(8, 1'b0, 1024, 0);
    set_pm1024();
    send(4'hF); send(4'hF);
    tick(); tick();
    check("t1_nchk", n_checked, 8);
    check("t1_done_early", done, 0);
    tick();
    check("t1_done", done, 1);
    check("t1_pass", pass, 1);
    check("t1_nerr", n_err, 0);
    check("t1_busy", busy, 0);

    // 2: one wrap-probing failure, one wrap-probing pass
    do_start(8, 1'b0, 1024, 0);
    set_pm1024();
    send(4'hF);
    g[2] = 32'hFFFF_FF00; s[2] = g[2] + 32'd1025;
    g[3] = 32'hFFFF_FF00; s[3] = 32'hFFFF_FFFF;
    send(4'hF);
    tick(); tick(); tick();
    check("t2_done", done, 1);
    check("t2_pass", pass, 0);
    check("t2_nerr", n_err, 1);
    check("t2_errch", err_ch, 4'b0100);
    check("t2_fvld", first_err_vld, 1);
    check("t2_fch", first_err_ch, 2);
    check("t2_fidx", first_err_idx, 6);
    check("t2_fgold", first_err_golden, 32'hFFFF_FF00);
    check("t2_fsim", first_err_sim, 32'h0000_0301);

    // 3: shift-equal mode, then a beat in DONE
    do_start(2, 1'b1, 0, 12);
    g[0] = 32'h1000_0FFF; s[0] = 32'h1000_0000;
    g[1] = 32'h1000_0FFF; s[1] = 32'h1000_1000;
    send(4'b0011);
    tick(); tick(); tick();
    check("t3_done", done, 1);
    check("t3_nchk", n_checked, 2);
    check("t3_nerr", n_err, 1);
    check("t3_fch", first_err_ch, 1);
    check("t3_fidx", first_err_idx, 1);
    check("t3_ovr0", overrun, 0);
    send(4'b0001); tick(); tick();
    check("t3_ovr_done", overrun, 1);
    check("t3_nchk_after", n_checked, 2);

    // 4: partial beat, dropped channel carries a mismatch
    do_start(6, 1'b0, 0, 0);
    for (int c = 0; c < 4; c++) begin g[c] = 32'h0A0B_0C00 + c; s[c] = g[c]; end
    send(4'hF);
    s[3] = g[3] ^ 32'h1;
    send(4'hF);
    tick(); tick(); tick();
    check("t4_done", done, 1);
    check("t4_nchk", n_checked, 6);
    check("t4_nerr", n_err, 0);
    check("t4_ovr", overrun, 1);
    check("t4_pass", pass, 0);

    // 5: async reset mid-run, then empty run
    do_start(8, 1'b0, 1024, 0);
    set_pm1024();
    send(4'hF); tick(); tick();
    check("t5_nchk_pre", n_checked, 4);
    check("t5_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_nchk", n_checked, 0);
    tick();
    rst = 1'b0;
    do_start(0, 1'b0, 0, 0);
    tick(); tick();
    check("t5_done_early", done, 0);
    check("t5_busy", busy, 1);
    tick();
    check("t5_done", done, 1);
    check("t5_pass", pass, 1);

    // 6: restart flushes in-flight failures; start beats a simultaneous beat
    do_start(8, 1'b0, 0, 0);
    for (int c = 0; c < 4; c++) begin g[c] = 32'h0000_0100 * (c + 1); s[c] = g[c] + 32'd5; end
    send(4'hF);
    load_bus(4'hF);
    do_start(4, 1'b0, 0, 0);
    bus.in_vld = 4'b0;
    tick(); tick(); tick();
    check("t6_nerr", n_err, 0);
    check("t6_nchk", n_checked, 0);
    check("t6_errch", err_ch, 0);
    check("t6_fvld", first_err_vld, 0);
    check("t6_busy", busy, 1);
    for (int c = 0; c < 4; c++) s[c] = g[c];
    send(4'hF);
    tick(); tick(); tick();
    check("t6_done", done, 1);
    check("t6_pass", pass, 1);
    check("t6_nchk_final", n_checked, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
